// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: debug-unit shared loader state encoding and program-format constants
package instr_loader_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instr_word_assembler.sv
// instr_word_assembler: packs received bytes MSB-first into 32-bit words
module instr_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  import instr_loader_pkg::*;
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic        w_take;
  assign w_take = i_en && i_rx_done;
  // the final byte bypasses the register so the word is usable on the strobe cycle
  assign o_word = {r_shift, i_rx_data};
  assign o_word_valid = w_take && (r_cnt == 2'(BYTES_PER_WORD - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_shift <= {r_shift[15:0], i_rx_data};
      r_cnt   <= r_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams UART bytes into instruction memory until HALT_WORD or full
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of all written words.
module instr_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] HALT_WORD = instr_loader_pkg::HALT_WORD,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  output logic             o_wr_instruction,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_data_instruction,
  output logic             o_busy,
  output logic             o_load_done,
  output logic             o_load_error,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]      o_checksum,
`endif
  output logic [CNT_W-1:0] o_word_count
);
  import instr_loader_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t      r_state;
  logic [AW-1:0] r_addr;
  logic        w_clear, w_word_valid;
  logic [31:0] w_word;
  assign w_clear = i_load_start && (r_state == IDLE || r_state == DONE);
  assign o_wr_addr = 32'(r_addr);
  instr_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_en         (r_state == RECV || r_state == WRITE),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= IDLE;
      r_addr             <= '0;
      o_wr_instruction   <= 1'b0;
      o_data_instruction <= '0;
      o_busy             <= 1'b0;
      o_load_done        <= 1'b0;
      o_load_error       <= 1'b0;
      o_word_count       <= '0;
`ifdef LOADER_CHECKSUM_EN
      o_checksum         <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: if (i_load_start) begin
          r_state      <= RECV;
          r_addr       <= '0;
          o_word_count <= '0;
          o_busy       <= 1'b1;
          o_load_done  <= 1'b0;
          o_load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          o_checksum   <= '0;
`endif
        end
        RECV: if (w_word_valid) begin
          o_data_instruction <= w_word;
          o_wr_instruction   <= 1'b1;
          r_state            <= WRITE;
        end
        WRITE: begin
          o_wr_instruction <= 1'b0;
          o_word_count     <= o_word_count + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          o_checksum       <= o_checksum ^ o_data_instruction;
`endif
          // saturate so the address never points past the last word
          if (r_addr != LAST) r_addr <= r_addr + AW'(1);
          if (o_data_instruction == HALT_WORD || r_addr == LAST) begin
            r_state      <= DONE;
            o_busy       <= 1'b0;
            o_load_done  <= 1'b1;
            o_load_error <= o_data_instruction != HALT_WORD;
          end else r_state <= RECV;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader (DEPTH=32)
module tb_instr_loader;
  logic        clk = 0, rst = 1, load_start = 0, rx_done = 0;
  logic [7:0]  rx_data = 0;
  logic        wr_instruction, busy, load_done, load_error;
  logic [31:0] wr_addr, data_instruction;
  logic [5:0]  word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int total = 0, bad = 0, exp_addr = 0;
  logic [63:0] q[$];

  instr_loader dut (
    .clk(clk), .rst(rst), .i_load_start(load_start), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_instruction(wr_instruction), .o_wr_addr(wr_addr), .o_data_instruction(data_instruction),
    .o_busy(busy), .o_load_done(load_done), .o_load_error(load_error),
`ifdef LOADER_CHECKSUM_EN
    .o_checksum(checksum),
`endif
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && wr_instruction) begin
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_write addr=%h data=%h", wr_addr, data_instruction);
    end else begin
      logic [63:0] e;
      e = q.pop_front();
      if ({wr_addr, data_instruction} !== e) begin
        bad++;
        $display("FAIL write got addr=%h data=%h want addr=%h data=%h", wr_addr, data_instruction, e[63:32], e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
    exp_addr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    @(negedge clk) begin rx_done = 1; rx_data = b; end
    if (gap) @(negedge clk) rx_done = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit expect_wr);
    if (expect_wr) begin
      q.push_back({32'(exp_addr), w});
      exp_addr++;
    end
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    if (!gap) @(negedge clk) rx_done = 0;
  endtask

  task automatic settle_and_check(input string tag, input logic [5:0] cnt, input logic done, input logic err);
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL %s pending_writes got=%0d want=0", tag, q.size()); end
    total++;
    if ({word_count, load_done, load_error, busy} !== {cnt, done, err, 1'b0}) begin
      bad++;
      $display("FAIL %s status got cnt=%0d done=%b err=%b busy=%b want cnt=%0d done=%b err=%b busy=0",
               tag, word_count, load_done, load_error, busy, cnt, done, err);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if ({wr_instruction, wr_addr, data_instruction, busy, load_done, load_error, word_count} !== '0) begin
      bad++;
      $display("FAIL %s reset_vals got wr=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%0d want all 0",
               tag, wr_instruction, wr_addr, data_instruction, busy, load_done, load_error, word_count);
    end
  endtask

  task automatic check_started(input string tag);
    total++;
    if ({busy, load_done, load_error, word_count} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
      bad++;
      $display("FAIL %s start got busy=%b done=%b err=%b cnt=%0d want busy=1 done=0 err=0 cnt=0",
               tag, busy, load_done, load_error, word_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
  endtask

  task automatic test_halt();
    pulse_start();
    check_started("halt");
    send_word(32'h0022_1820, 1, 1);
    send_word(32'hFFFF_FFFF, 1, 1);
    settle_and_check("halt", 6'd2, 1, 0);
  endtask

  task automatic test_full();
    pulse_start();
    for (int i = 0; i < 32; i++) send_word(32'h1000_0000 + 32'(i * 3), 1, 1);
    settle_and_check("full", 6'd32, 1, 1);
    send_word(32'hAABB_CCDD, 1, 0);
    settle_and_check("full_extra", 6'd32, 1, 1);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h56, 1);
    @(negedge clk) rst = 1;
    #1 check_reset_vals("mid_rst");
    @(negedge clk) rst = 0;
    send_word(32'h7777_0000, 1, 0);
    settle_and_check("idle_rx", 6'd0, 0, 0);
    pulse_start();
    send_word(32'hCAFE_BABE, 1, 1);
    send_word(32'hFFFF_FFFF, 1, 1);
    settle_and_check("after_rst", 6'd2, 1, 0);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_word(32'h1122_3344, 0, 1);
    send_word(32'h5566_7788, 0, 1);
    send_word(32'hFFFF_FFFF, 0, 1);
    settle_and_check("b2b", 6'd3, 1, 0);
  endtask

  task automatic test_ignore();
    send_word(32'h0BAD_0BAD, 1, 0);
    settle_and_check("done_rx", 6'd3, 1, 0);
    pulse_start();
    check_started("restart");
    send_word(32'h0000_00A1, 1, 1);
    send_byte(8'hB2, 1);
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
    send_byte(8'hB3, 1); send_byte(8'hB4, 1);
    @(negedge clk) load_start = 1;
    send_byte(8'hB5, 1);
    load_start = 0;
    q.push_back({32'(exp_addr), 32'hB2B3_B4B5}); exp_addr++;
    send_word(32'hFFFF_FFFF, 1, 1);
    settle_and_check("ignore", 6'd3, 1, 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'd1, 1, 1);
    send_word(32'd2, 1, 1);
    send_word(32'hFFFF_FFFF, 1, 1);
    settle_and_check("csum", 6'd3, 1, 0);
    total++;
    if (checksum !== 32'hFFFF_FFFC) begin bad++; $display("FAIL checksum got=%h want=fffffffc", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_halt();
    test_full();
    test_reset_mid();
    test_back_to_back();
    test_ignore();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
